// File: rtl/jesd204_scrambler_lanes.sv
// Multi-lane self-synchronising 1 + x^39 + x^58 scrambler/descrambler with per-lane lock.
// Optional macro JESD204_SCRAMBLER_STATE_LOAD_EN adds a broadcast state preload (state_load/state_value).
module jesd204_scrambler_lanes #(
  parameter int          NUM_LANES  = 4,
  parameter int          DATA_WIDTH = 64,
  parameter bit          DESCRAMBLE = 1'b0,
  parameter logic [57:0] INIT_STATE = 58'h3ffffffffffffff
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_LANES-1:0]            enable,
  input  logic                            in_valid,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] data_in,
`ifdef JESD204_SCRAMBLER_STATE_LOAD_EN
  input  logic                            state_load,
  input  logic [57:0]                     state_value,
`endif
  output logic                            out_valid,
  output logic [NUM_LANES*DATA_WIDTH-1:0] data_out,
  output logic [NUM_LANES-1:0]            out_locked
);

  localparam int STATE_BITS = 58;
  localparam int CNT_W      = $clog2(STATE_BITS + DATA_WIDTH);
  localparam logic [CNT_W-1:0] LOCK_COUNT = CNT_W'(STATE_BITS);
  localparam logic [CNT_W-1:0] BEAT_COUNT = CNT_W'(DATA_WIDTH);

  logic [57:0]                     state_r      [NUM_LANES];
  logic [CNT_W-1:0]                count_r      [NUM_LANES];
  logic [57:0]                     base_state_s [NUM_LANES];
  logic [CNT_W-1:0]                base_count_s [NUM_LANES];
  logic [57:0]                     step_state_s [NUM_LANES];
  logic [DATA_WIDTH-1:0]           step_word_s  [NUM_LANES];
  logic [57:0]                     state_next_s [NUM_LANES];
  logic [CNT_W-1:0]                count_next_s [NUM_LANES];
  logic [NUM_LANES*DATA_WIDTH-1:0] data_next_s;
  logic [NUM_LANES-1:0]            locked_next_s;

  // One beat of one lane, bit 0 first; the state always absorbs the line-side bit, even in bypass.
  function automatic void lane_step(
    input  logic [57:0]           state_in,
    input  logic [DATA_WIDTH-1:0] word,
    input  logic                  bypass,
    output logic [57:0]           state_out,
    output logic [DATA_WIDTH-1:0] word_out
  );
    logic feedback;
    logic line_bit;
    state_out = state_in;
    word_out  = word;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      feedback = state_out[38] ^ state_out[57];
      if (DESCRAMBLE) begin
        line_bit    = word[i];
        word_out[i] = bypass ? word[i] : (word[i] ^ feedback);
      end else begin
        line_bit    = bypass ? word[i] : (word[i] ^ feedback);
        word_out[i] = line_bit;
      end
      state_out = {state_out[56:0], line_bit};
    end
  endfunction

  // Next-state, lock counter and output beat for every lane.
  always_comb begin
    data_next_s   = data_out;
    locked_next_s = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      base_state_s[l] = state_r[l];
      base_count_s[l] = count_r[l];
`ifdef JESD204_SCRAMBLER_STATE_LOAD_EN
      // A load takes effect before the beat sampled on the same edge is processed.
      if (state_load) begin
        base_state_s[l] = state_value;
        base_count_s[l] = LOCK_COUNT;
      end else begin
        base_state_s[l] = state_r[l];
        base_count_s[l] = count_r[l];
      end
`endif
      lane_step(base_state_s[l], data_in[l*DATA_WIDTH +: DATA_WIDTH], ~enable[l],
                step_state_s[l], step_word_s[l]);
      if (in_valid) begin
        state_next_s[l] = step_state_s[l];
        count_next_s[l] = (base_count_s[l] >= LOCK_COUNT) ? base_count_s[l]
                                                          : base_count_s[l] + BEAT_COUNT;
        data_next_s[l*DATA_WIDTH +: DATA_WIDTH] = step_word_s[l];
      end else begin
        state_next_s[l] = base_state_s[l];
        count_next_s[l] = base_count_s[l];
      end
      locked_next_s[l] = (count_next_s[l] >= LOCK_COUNT);
    end
  end

  // Lane state, lock counters and the registered output beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        state_r[l] <= INIT_STATE;
        count_r[l] <= '0;
      end
      out_valid  <= 1'b0;
      data_out   <= '0;
      out_locked <= '0;
    end else begin
      for (int l = 0; l < NUM_LANES; l++) begin
        state_r[l] <= state_next_s[l];
        count_r[l] <= count_next_s[l];
      end
      out_valid  <= in_valid;
      data_out   <= data_next_s;
      out_locked <= locked_next_s;
    end
  end

endmodule
